ddr4_dma_writer: RTL
====================

# ddr4_dma_writer

AXI4-Stream to AXI4 memory-mapped write master that moves a commanded number of stream beats into PL DDR4.
- Sits directly upstream of the DDR4 controller's AXI slave port inside `system`, and runs on the controller's UI clock.
- Splits each command into INCR bursts that never cross a 4 KB boundary.
- Tracks write responses and signals completion and error.

## Interface
- `ADDR_W`, 29, byte address width, matching the DDR4 AXI slave.
- `DATA_W`, 512, data width in bits; bytes per beat `BPB = DATA_W/8`.
- `MAX_BURST`, 64, maximum beats per burst (1..256).
- `MAX_OUTST`, 8, maximum AW bursts issued without their B response.

Ports:
- `clk` in 1: UI clock; all logic is in this domain.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1 / `cmd_ready` out 1: command handshake.
- `cmd_addr` in `ADDR_W`: start byte address; the low log2(BPB) bits are ignored and treated as zero.
- `cmd_beats` in 16: number of beats to write; 0 is legal.
- `s_axis_tvalid` in 1 / `s_axis_tready` out 1 / `s_axis_tdata` in `DATA_W`: input data stream.
- `m_axi_awaddr` out `ADDR_W`, `m_axi_awlen` out 8, `m_axi_awsize` out 3, `m_axi_awburst` out 2, `m_axi_awvalid` out 1, `m_axi_awready` in 1: write-address channel.
- `m_axi_wdata` out `DATA_W`, `m_axi_wstrb` out `BPB`, `m_axi_wlast` out 1, `m_axi_wvalid` out 1, `m_axi_wready` in 1: write-data channel.
- `m_axi_bresp` in 2, `m_axi_bvalid` in 1, `m_axi_bready` out 1: write-response channel.
- `busy` out 1: high from command accept until `done`.
- `done` out 1: one-cycle pulse when the command is complete.
- `error` out 1: sticky; set by any non-OKAY response.

## Operation
- FSM states: IDLE, AW, W, WAIT_B.
- **IDLE**
  - `cmd_ready`=1.
  - On accept, latch address and remaining beat count, clear `error`, set `busy`.
  - If `cmd_beats`=0, go directly to WAIT_B; otherwise go to AW.
- **AW**
  - Compute `blen = min(remaining, MAX_BURST, (4096 - addr[11:0])/BPB)`.
  - Drive `awaddr`=addr, `awlen`=blen-1, `awsize`=log2(BPB), `awburst`=INCR (2'b01).
  - `awvalid` is raised only when the outstanding count is below `MAX_OUTST`.
  - On handshake: outstanding += 1, `addr += blen*BPB`, `remaining -= blen`, load beat counter = blen, go to W.
- **W**
  - Combinational pass-through: `wvalid = s_axis_tvalid`, `s_axis_tready = wready`, `wdata = tdata`, `wstrb` all ones.
  - `wlast` is high when the beat counter equals 1.
  - The beat counter decrements on each W handshake.
  - After the last beat: go to AW if `remaining`>0, otherwise go to WAIT_B.
- **WAIT_B**
  - When the outstanding count is 0, pulse `done`, clear `busy`, and return to IDLE.
- **B channel**
  - `bready`=1 in every state except IDLE; responses are taken whenever they arrive, including during AW and W.
  - Each B handshake decrements the outstanding count.
  - Any `bresp`≠2'b00 sets `error`. `error` holds until the next command is accepted.
- **Simultaneous AW and B handshakes** in the same cycle: the outstanding count is unchanged.
- **Unexpected B** (a B response when the outstanding count is 0): ignored; the count saturates at 0 and `error` is set.
- **Reset** (at any time, including mid-burst):
  - All `valid`, `ready`, `busy`, `done` and `error` outputs go to 0.
  - All counters clear and the FSM returns to IDLE.
  - An in-flight burst is abandoned; the system-level reset clears the slave as well.
  - After reset deassertion, the FSM is in IDLE with `cmd_ready`=1.
- **Arithmetic**
  - Address addition wraps modulo 2^`ADDR_W`.
  - Counters are 16 bits wide; `remaining` never underflows because `blen` ≤ `remaining`.

## Timing
- `awvalid` rises the cycle after command accept (or after the last W beat), provided outstanding < `MAX_OUTST`.
- `awvalid`, `awaddr` and `awlen` are registered and held stable until `awready`.
- The first `wvalid` can occur the cycle after the AW handshake.
- Data path: zero latency, no W buffering; throughput is one beat per cycle while `tvalid` and `wready` are both high.
- `done` asserts the cycle after the final B handshake, or, for a zero-beat command, the cycle after accept.

## Structure
- Package `ddr4_dma_pkg` holds:
  - the `AXI_BURST_INCR` and `AXI_RESP_OKAY` constants;
  - the FSM state enum `dma_wr_state_t`;
  - the 4 KB boundary constant.
- Sub-module `dma_burst_calc`: combinational computation of `blen` from `addr`, `remaining`, `MAX_BURST` and `BPB`; it is reused by the planned read engine.

## Test plan
- addr 0x0000_0000, 128 beats, slave always ready → two AW (awlen=63, addresses 0x0 and 0x1000), 128 W beats, `wlast` on beats 64 and 128, one `done` pulse, `error`=0.
- addr 0x0000_0FC0, 3 beats → first AW awlen=0 at 0x0FC0, second AW awlen=1 at 0x1000; no 4 KB crossing.
- `cmd_beats`=0 → no AXI traffic; `done` pulses the cycle after accept.
- B responses withheld, `MAX_OUTST`=8, 1024 beats → exactly 8 AW issued, then `awvalid` stays low until a B arrives.
- A SLVERR response on the 2nd burst → `error`=1 at `done`, and `error`=0 again after the next command is accepted.
- `reset_n` pulled low mid-W with `tvalid` held high → all valid and ready outputs are 0 within the reset cycle; after release, the FSM is in IDLE with `cmd_ready`=1.

Source files
------------

// File: rtl/ddr4_dma_pkg.sv
// Shared AXI constants, FSM state type and helpers for the DDR4 DMA engines.
package ddr4_dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam int unsigned BOUNDARY_4K = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_WAIT_B
  } dma_wr_state_t;

  function automatic logic [15:0] min_u16(input logic [15:0] a, input logic [15:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Burst length for the next INCR burst: limited by remaining beats, the burst
// cap and the distance to the next 4 KB boundary.
module dma_burst_calc
  import ddr4_dma_pkg::*;
#(
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned BPB       = 64
) (
  input  logic [11:0] addr_offset,
  input  logic [15:0] remaining,
  output logic [15:0] blen
);

  localparam int unsigned BPB_LOG2    = $clog2(BPB);
  localparam logic [15:0] MAX_BURST_W = 16'(MAX_BURST);

  logic [12:0] bytes_to_bdry;
  logic [15:0] beats_to_bdry;

  // addr_offset is beat-aligned, so the shift is an exact division
  always_comb begin
    bytes_to_bdry = 13'(BOUNDARY_4K) - {1'b0, addr_offset};
    beats_to_bdry = 16'(bytes_to_bdry >> BPB_LOG2);
    blen          = min_u16(min_u16(remaining, MAX_BURST_W), beats_to_bdry);
  end

endmodule

// File: rtl/ddr4_dma_writer.sv
// AXI4-Stream to AXI4 write master: splits a beat-count command into 4 KB-safe
// INCR bursts, streams data with zero latency and tracks B responses.
module ddr4_dma_writer
  import ddr4_dma_pkg::*;
#(
  parameter int unsigned ADDR_W    = 29,
  parameter int unsigned DATA_W    = 512,
  parameter int unsigned MAX_BURST = 64,
  parameter int unsigned MAX_OUTST = 8,
  localparam int unsigned BPB      = DATA_W / 8
) (
  input  logic                clk,
  input  logic                reset_n,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [15:0]         cmd_beats,

  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  input  logic [DATA_W-1:0]   s_axis_tdata,

  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,

  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [BPB-1:0]      m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,

  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,

  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int unsigned BPB_LOG2   = $clog2(BPB);
  localparam int unsigned OW         = $clog2(MAX_OUTST + 1);
  localparam logic [OW-1:0] OUTST_MAX = OW'(MAX_OUTST);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BPB - 1);

  dma_wr_state_t       state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         remaining_q, remaining_d;
  logic [15:0]         beat_cnt_q, beat_cnt_d;
  logic [OW-1:0]       outst_q, outst_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;
  logic                awvalid_q, awvalid_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [7:0]          awlen_q, awlen_d;

  logic [15:0]         blen;
  logic [15:0]         issued_beats;
  logic                aw_hs, w_hs, b_hs, b_unexp, b_match;

  // Burst length is taken from the next-cycle address/remaining so that the
  // registered AW fields are already valid when awvalid rises.
  dma_burst_calc #(
    .MAX_BURST (MAX_BURST),
    .BPB       (BPB)
  ) u_burst_calc (
    .addr_offset (addr_d[11:0]),
    .remaining   (remaining_d),
    .blen        (blen)
  );

  assign cmd_ready     = reset_n && (state_q == ST_IDLE);
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = 3'(BPB_LOG2);
  assign m_axi_awburst = AXI_BURST_INCR;

  assign m_axi_wvalid  = (state_q == ST_W) && s_axis_tvalid;
  assign s_axis_tready = (state_q == ST_W) && m_axi_wready;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = (state_q == ST_W) && (beat_cnt_q == 16'd1);

  assign m_axi_bready  = (state_q != ST_IDLE);

  assign busy  = busy_q;
  assign done  = (state_q == ST_WAIT_B) && (outst_q == '0);
  assign error = error_q;

  assign aw_hs        = awvalid_q && m_axi_awready;
  assign w_hs         = m_axi_wvalid && m_axi_wready;
  assign b_hs         = m_axi_bready && m_axi_bvalid;
  assign b_unexp      = b_hs && (outst_q == '0) && !aw_hs;
  assign b_match      = b_hs && !b_unexp;
  assign issued_beats = {8'd0, awlen_q} + 16'd1;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    busy_d      = busy_q;
    error_d     = error_q;
    outst_d     = outst_q;

    if (aw_hs && !b_match) begin
      outst_d = outst_q + OW'(1);
    end else if (!aw_hs && b_match) begin
      outst_d = outst_q - OW'(1);
    end

    if (b_hs && ((m_axi_bresp != AXI_RESP_OKAY) || b_unexp)) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr & ALIGN_MASK;
          remaining_d = cmd_beats;
          error_d     = 1'b0;
          busy_d      = 1'b1;
          state_d     = (cmd_beats == 16'd0) ? ST_WAIT_B : ST_AW;
        end
      end
      ST_AW: begin
        if (aw_hs) begin
          addr_d      = addr_q + (ADDR_W'(issued_beats) << BPB_LOG2);
          remaining_d = remaining_q - issued_beats;
          beat_cnt_d  = issued_beats;
          state_d     = ST_W;
        end
      end
      ST_W: begin
        if (w_hs) begin
          beat_cnt_d = beat_cnt_q - 16'd1;
          if (beat_cnt_q == 16'd1) begin
            state_d = (remaining_q != 16'd0) ? ST_AW : ST_WAIT_B;
          end
        end
      end
      ST_WAIT_B: begin
        if (outst_q == '0) begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Kept apart from the FSM block: it consumes blen, which is derived from addr_d.
  always_comb begin
    awvalid_d = (state_d == ST_AW) && (outst_d < OUTST_MAX);
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    if (!awvalid_q) begin
      awaddr_d = addr_d;
      awlen_d  = 8'(blen - 16'd1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beat_cnt_q  <= '0;
      outst_q     <= '0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
      outst_q     <= outst_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      awvalid_q   <= awvalid_d;
      awaddr_q    <= awaddr_d;
      awlen_q     <= awlen_d;
    end
  end

endmodule
